// File: rtl/tcp_tx_scheduler_if.sv
// Shared types and the port bundle for tcp_tx_scheduler.
//
// tcp_tx_pkg::tcp_packet_info_s is the header/control record handed to tcp_sender.
// tcp_tx_scheduler_if carries every non-clock signal:
//   requester side : req, req_pkt, done, grant, s_tdata/s_tvalid/s_tlast/s_tready
//   sender side    : snd_start, snd_pkt, snd_busy, snd_tdata/snd_tvalid/snd_tlast/snd_tready
//   status         : err_timeout
// The master modport is the scheduler's view; slave is the surrounding logic's view.
package tcp_tx_pkg;
  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] seq;
    logic [31:0] ack;
    logic [7:0]  flags;
    logic [15:0] payload_len;
  } tcp_packet_info_s;
endpackage

interface tcp_tx_scheduler_if #(parameter int NUM_REQ = 3);
  logic [NUM_REQ-1:0]                          req;
  tcp_tx_pkg::tcp_packet_info_s [NUM_REQ-1:0]  req_pkt;
  logic [NUM_REQ-1:0]                          done;
  logic [NUM_REQ-1:0]                          grant;
  logic                                        err_timeout;
  logic [NUM_REQ*8-1:0]                        s_tdata;
  logic [NUM_REQ-1:0]                          s_tvalid;
  logic [NUM_REQ-1:0]                          s_tlast;
  logic [NUM_REQ-1:0]                          s_tready;
  logic                                        snd_start;
  tcp_tx_pkg::tcp_packet_info_s                snd_pkt;
  logic                                        snd_busy;
  logic [7:0]                                  snd_tdata;
  logic                                        snd_tvalid;
  logic                                        snd_tlast;
  logic                                        snd_tready;

  modport master (
    input  req, req_pkt, s_tdata, s_tvalid, s_tlast, snd_busy, snd_tready,
    output done, grant, err_timeout, s_tready, snd_start, snd_pkt,
           snd_tdata, snd_tvalid, snd_tlast
  );

  modport slave (
    output req, req_pkt, s_tdata, s_tvalid, s_tlast, snd_busy, snd_tready,
    input  done, grant, err_timeout, s_tready, snd_start, snd_pkt,
           snd_tdata, snd_tvalid, snd_tlast
  );
endinterface

// File: rtl/tcp_tx_scheduler.sv
// tcp_tx_scheduler: round-robin sharing of one tcp_sender between NUM_REQ sources.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous reset, active high
//   bus  - tcp_tx_scheduler_if.master (requests, per-requester payload lanes,
//          sender control/payload, done/grant/err_timeout status)
//
// Flow: IDLE picks a winner and latches its packet info, ISSUE pulses snd_start,
// WAIT_BUSY waits (bounded by BUSY_TIMEOUT) for the sender to go busy, RUN waits
// for busy to fall, DONE pulses done to the winner and advances the RR pointer.
// The payload lane of the winner is muxed to the sender in WAIT_BUSY and RUN.
module tcp_tx_scheduler #(
  parameter int NUM_REQ      = 3,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  tcp_tx_scheduler_if.master bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, RUN, DONE} state_e;

  state_e                       state_q;
  logic [IW-1:0]                rr_ptr_q, win_q;
  logic [CW-1:0]                cnt_q;
  logic [NUM_REQ-1:0]           grant_q, done_q;
  logic                         start_q, err_q;
  tcp_tx_pkg::tcp_packet_info_s pkt_q;

  // Round-robin pick: scan from the far end back toward rr_ptr so the last hit
  // (the one that sticks) is the first set request at or after rr_ptr.
  logic [IW-1:0] pick_d, idx;
  logic          pick_vld_d;
  always_comb begin
    pick_d     = '0;
    pick_vld_d = 1'b0;
    idx        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (bus.req[idx]) begin
        pick_d     = idx;
        pick_vld_d = 1'b1;
      end
    end
  end

  logic [IW-1:0] rr_nxt;
  assign rr_nxt = (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      pkt_q    <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= '0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: if (pick_vld_d) begin
          win_q   <= pick_d;
          grant_q <= NUM_REQ'(1) << pick_d;
          pkt_q   <= bus.req_pkt[pick_d];
          start_q <= 1'b1;
          state_q <= ISSUE;
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // A busy that is already high here is taken as this frame's start.
          if (bus.snd_busy) begin
            state_q <= RUN;
          end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            done_q  <= grant_q;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: if (!bus.snd_busy) begin
          done_q  <= grant_q;
          state_q <= DONE;
        end
        DONE: begin
          grant_q  <= '0;
          rr_ptr_q <= rr_nxt;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Payload mux, open only while a frame is in flight.
  logic               open_w;
  logic [7:0]         tdata_w;
  logic               tvalid_w, tlast_w;
  logic [NUM_REQ-1:0] tready_w;
  assign open_w = (state_q == WAIT_BUSY) || (state_q == RUN);

  always_comb begin
    tdata_w  = '0;
    tvalid_w = 1'b0;
    tlast_w  = 1'b0;
    tready_w = '0;
    if (open_w) begin
      tdata_w         = bus.s_tdata[{win_q, 3'b000} +: 8];
      tvalid_w        = bus.s_tvalid[win_q];
      tlast_w         = bus.s_tlast[win_q];
      tready_w[win_q] = bus.snd_tready;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.done        = done_q;
  assign bus.snd_start   = start_q;
  assign bus.err_timeout = err_q;
  assign bus.snd_pkt     = pkt_q;
  assign bus.snd_tdata   = tdata_w;
  assign bus.snd_tvalid  = tvalid_w;
  assign bus.snd_tlast   = tlast_w;
  assign bus.s_tready    = tready_w;
endmodule

// File: tb/tb_tcp_tx_scheduler.sv
// Bench for tcp_tx_scheduler: a tiny tcp_sender stand-in drives busy/tready,
// per-lane payload sources feed counting bytes, and a transaction-level model
// (owner / phase / wait count) predicts every output each cycle.
module tb_tcp_tx_scheduler;
  import tcp_tx_pkg::*;
  localparam int N  = 3;
  localparam int BT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tcp_tx_scheduler_if #(.NUM_REQ(N)) bus();
  tcp_tx_scheduler #(.NUM_REQ(N), .BUSY_TIMEOUT(BT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- environment state ----------------
  bit   lane_on[N], lane_tog[N], lane_fire[N];
  int   lane_len[N], lane_cnt[N];
  bit   tog_ph = 0;
  bit   stub_en = 1, mon_start = 0, got_last = 0, stall_done = 0;
  int   stub_st = 0, stub_dly = 0, stub_run = 0, cur_len = 0;
  int   stall_at = -1, stall_left = 0, stall_cnt = 0;
  int   rx_n = 0;
  logic [7:0] rx_q[$];
  int   start_cyc = -1, err_cyc = -1, done_cyc = -1, start_cnt = 0, done_total = 0;
  int   done_cnt[N];
  int   grant_log[$];
  logic [N-1:0] prev_g = '0;

  // ---------------- model ----------------
  int   m_own = -1, m_t = 0, m_wait = 0, m_rr = 0;
  bit   m_run = 0, m_fin = 0, m_err = 0;
  tcp_packet_info_s m_pkt = '0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_own = -1; m_t = 0; m_wait = 0; m_rr = 0; m_run = 0; m_fin = 0; m_err = 0; m_pkt = '0;
    end else begin
      bit e;
      int pick;
      e = 0;
      pick = -1;
      if (m_own < 0) begin
        for (int k = 0; k < N; k++)
          if (pick < 0 && bus.req[(m_rr + k) % N]) pick = (m_rr + k) % N;
        if (pick >= 0) begin
          m_own = pick; m_t = 1; m_pkt = bus.req_pkt[pick];
          m_wait = 0; m_run = 0; m_fin = 0;
        end
      end else if (m_fin) begin
        m_rr = (m_own + 1) % N; m_own = -1; m_fin = 0;
      end else if (m_t == 1) begin
        m_t = 2;
      end else if (!m_run) begin
        if (bus.snd_busy) m_run = 1;
        else begin
          m_wait++;
          if (m_wait == BT) begin m_fin = 1; e = 1; end
        end
      end else if (!bus.snd_busy) begin
        m_fin = 1;
      end
      m_err = e;
    end
  end

  // ---------------- sender stand-in and payload lanes ----------------
  initial begin
    bus.s_tdata = '0; bus.s_tvalid = '0; bus.s_tlast = '0;
    bus.snd_busy = 1'b0; bus.snd_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        stub_st = 0; bus.snd_busy = 1'b0; stall_left = 0; got_last = 0;
      end else begin
        for (int i = 0; i < N; i++) if (lane_fire[i]) lane_cnt[i]++;
        tog_ph = ~tog_ph;
        case (stub_st)
          0: if (mon_start && stub_en) begin stub_st = 1; stub_dly = 2; end
          1: begin
            stub_dly--;
            if (stub_dly == 0) begin stub_st = 2; bus.snd_busy = 1'b1; stub_run = 0; end
          end
          default: begin
            stub_run++;
            if (cur_len == 0 ? stub_run >= 3 : got_last) begin
              stub_st = 0; bus.snd_busy = 1'b0; got_last = 0;
            end
          end
        endcase
        if (stub_st == 2 && stall_at >= 0 && !stall_done && rx_n >= stall_at) begin
          stall_left = 20; stall_done = 1;
        end
      end
      if (stall_left > 0) begin bus.snd_tready = 1'b0; stall_left--; end
      else bus.snd_tready = (stub_st == 2);
      for (int i = 0; i < N; i++) begin
        bus.s_tvalid[i] = lane_on[i] && lane_cnt[i] < lane_len[i] && (!lane_tog[i] || tog_ph);
        bus.s_tlast[i]  = lane_on[i] && lane_cnt[i] == lane_len[i] - 1;
        bus.s_tdata[8*i +: 8] = 8'(i * 64 + lane_cnt[i]);
      end
    end
  end

  // ---------------- monitor + per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < N; i++) lane_fire[i] = bus.s_tvalid[i] && bus.s_tready[i];
    mon_start = bus.snd_start;
    if (bus.snd_tvalid && bus.snd_tready) begin
      rx_q.push_back(bus.snd_tdata); rx_n++;
      if (bus.snd_tlast) got_last = 1;
    end
    if (stub_st == 2 && bus.snd_tvalid && !bus.snd_tready) stall_cnt++;
    if (bus.snd_start) begin start_cyc = cyc; start_cnt++; end
    if (bus.err_timeout) err_cyc = cyc;
    for (int i = 0; i < N; i++)
      if (bus.done[i]) begin done_cnt[i]++; done_total++; done_cyc = cyc; end
    if (bus.grant != 0 && prev_g == 0)
      for (int i = 0; i < N; i++) if (bus.grant[i]) grant_log.push_back(i);
    prev_g = bus.grant;
    if (!rst) begin
      logic [N-1:0] eg, ed, etr;
      bit eo, ev, el;
      eg = '0; ed = '0; etr = '0; eo = 0; ev = 0; el = 0;
      if (m_own >= 0) begin
        eg[m_own] = 1'b1;
        if (m_fin) ed[m_own] = 1'b1;
        eo = (m_t == 2) && !m_fin;
        if (eo) begin
          ev = bus.s_tvalid[m_own]; el = bus.s_tlast[m_own]; etr[m_own] = bus.snd_tready;
          chk("snd_tdata", bus.snd_tdata, bus.s_tdata[8*m_own +: 8]);
        end
      end
      chk("grant", bus.grant, eg);
      chk("done", bus.done, ed);
      chk("snd_start", bus.snd_start, (m_own >= 0 && m_t == 1));
      chk("err_timeout", bus.err_timeout, m_err);
      chk("snd_pkt", bus.snd_pkt, m_pkt);
      chk("snd_tvalid", bus.snd_tvalid, ev);
      chk("snd_tlast", bus.snd_tlast, el);
      chk("s_tready", bus.s_tready, etr);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_done(input int idx, input int budget, input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.done[idx] && n < budget);
    #1;
    chk(name, bus.done[idx], 1'b1);
  endtask

  task automatic lanes_off();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin lane_on[i] = 0; lane_tog[i] = 0; lane_len[i] = 0; lane_cnt[i] = 0; end
    rx_q.delete(); rx_n = 0; got_last = 0;
  endtask

  tcp_packet_info_s pktA, pktB, pktC, pktD, pktX;
  int rr_exp[6] = '{2, 0, 1, 2, 0, 1};
  int base, target, bad, sc, n, dc[N];

  initial begin
    pktA = '{16'h1234, 16'h0050, 32'h1000_0001, 32'h2000_0002, 8'h10, 16'd0};
    pktB = '{16'h2222, 16'h0051, 32'h3000_0003, 32'h4000_0004, 8'h18, 16'd100};
    pktC = '{16'h3333, 16'h0052, 32'h5000_0005, 32'h6000_0006, 8'h18, 16'd40};
    pktD = '{16'h4444, 16'h0053, 32'h7000_0007, 32'h8000_0008, 8'h02, 16'd0};
    pktX = '{16'hdead, 16'hbeef, 32'hffff_ffff, 32'hffff_ffff, 8'hff, 16'hffff};
    bus.req = '0; bus.req_pkt = '0;
    lanes_off();
    chk("reset_grant", bus.grant, 3'b000);
    chk("reset_start", bus.snd_start, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single requester 1, no payload.
    bus.req_pkt[1] = pktA; bus.req_pkt[0] = pktD; bus.req_pkt[2] = pktB;
    @(posedge clk); #1;
    bus.req = 3'b010; base = cyc;
    wait_done(1, 100, "t2_done");
    chk("t2_start_latency", start_cyc - base, 1);
    chk("t2_done_after_start", done_cyc - start_cyc, 7);
    chk("t2_pkt", bus.snd_pkt, pktA);
    @(posedge clk); #1 bus.req = '0;

    // All requesting: round-robin continues from pointer 2.
    base = grant_log.size(); target = done_total + 6;
    for (int i = 0; i < N; i++) dc[i] = done_cnt[i];
    @(posedge clk); #1 bus.req = 3'b111;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (done_total < target && n < 400);
    chk("t3_frames", done_total, target);
    @(posedge clk); #1 bus.req = '0;
    for (int i = 0; i < 6; i++)
      chk("t3_rr_order", (grant_log.size() > base + i) ? grant_log[base + i] : -1, rr_exp[i]);
    for (int i = 0; i < N; i++) chk("t3_done_count", done_cnt[i] - dc[i], 2);

    // Lane 2 carries 100 bytes while lane 0 toggles valid unserved.
    lanes_off();
    lane_on[2] = 1; lane_len[2] = 100;
    lane_on[0] = 1; lane_len[0] = 200; lane_tog[0] = 1;
    cur_len = 100;
    @(posedge clk); #1 bus.req = 3'b100;
    repeat (5) @(posedge clk);
    #1 bus.req_pkt[2] = pktX;
    wait_done(2, 400, "t4_done");
    chk("t4_pkt_held", bus.snd_pkt, pktB);
    chk("t4_bytes", rx_q.size(), 100);
    bad = 0;
    foreach (rx_q[k]) if (rx_q[k] !== 8'(128 + k)) bad++;
    chk("t4_byte_values", bad, 0);
    @(posedge clk); #1 bus.req = '0;

    // Lane 1, 40 bytes, sender stalls 20 cycles after byte 10; req dropped after latch.
    lanes_off();
    lane_on[1] = 1; lane_len[1] = 40; cur_len = 40;
    stall_at = 10; stall_done = 0; stall_cnt = 0;
    bus.req_pkt[1] = pktC;
    @(posedge clk); #1 bus.req = 3'b010;
    repeat (3) @(posedge clk);
    #1 bus.req = '0;
    wait_done(1, 400, "t6_done");
    chk("t6_bytes", rx_q.size(), 40);
    bad = 0;
    foreach (rx_q[k]) if (rx_q[k] !== 8'(64 + k)) bad++;
    chk("t6_byte_values", bad, 0);
    chk("t6_stall_cycles", stall_cnt, 20);
    stall_at = -1;

    // Sender never goes busy: timeout.
    lanes_off();
    cur_len = 0; stub_en = 0;
    @(posedge clk); #1 bus.req = 3'b001;
    wait_done(0, 100, "t5_done");
    chk("t5_err_delay", err_cyc - start_cyc, BT + 1);
    chk("t5_done_with_err", done_cyc, err_cyc);
    @(posedge clk); #1 bus.req = '0;
    @(negedge clk); stub_en = 1;

    // Reset in the middle of a running frame.
    lanes_off();
    lane_on[1] = 1; lane_len[1] = 30; cur_len = 30;
    bus.req_pkt[1] = pktA;
    @(posedge clk); #1 bus.req = 3'b010;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (rx_n < 5 && n < 100);
    chk("t1_reached_run", rx_n >= 5, 1'b1);
    @(posedge clk); #1 rst = 1'b1; bus.req = '0;
    #1;
    chk("t1_grant", bus.grant, 3'b000);
    chk("t1_done", bus.done, 3'b000);
    chk("t1_start", bus.snd_start, 1'b0);
    chk("t1_err", bus.err_timeout, 1'b0);
    chk("t1_pkt", bus.snd_pkt, 120'd0);
    chk("t1_tvalid", bus.snd_tvalid, 1'b0);
    chk("t1_tlast", bus.snd_tlast, 1'b0);
    chk("t1_s_tready", bus.s_tready, 3'b000);
    lanes_off();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sc = start_cnt;
    repeat (10) @(negedge clk);
    #1;
    chk("t1_no_start_after_reset", start_cnt - sc, 0);
    chk("t1_idle_grant", bus.grant, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
